seg7_scan_ctrl: RTL and testbench

//  Parametrised time-multiplexed 7-segment display controller for the board

---
 rtl/seg7_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: tear-free frame-boundary commit,
// per-digit enable/dp/blink, leading-zero blanking and PWM brightness.
module seg7_scan_ctrl #(
  parameter int unsigned NDIGITS    = 8,
  parameter int unsigned SCAN_BITS  = 17,
  parameter int unsigned BLINK_LOG2 = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [4*NDIGITS-1:0]   wr_data,
  input  logic [NDIGITS-1:0]     dig_en,
  input  logic [NDIGITS-1:0]     dp_in,
  input  logic [NDIGITS-1:0]     blink_mask,
  input  logic                   lz_en,
  input  logic [3:0]             bright,
  output logic                   upd_pending,
  output logic                   frame_tick,
  output logic [6:0]             a2g,
  output logic                   dp_n,
  output logic [NDIGITS-1:0]     an
);

  localparam int unsigned IdxW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NDIGITS - 1);

  logic [SCAN_BITS-1:0]  div_cnt_q, div_cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [BLINK_LOG2:0]   blink_cnt_q, blink_cnt_d;
  logic [4*NDIGITS-1:0]  shadow_q, shadow_d;
  logic [4*NDIGITS-1:0]  pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [NDIGITS-1:0]    an_q, an_d;
  logic [6:0]            a2g_q, a2g_d;
  logic                  dp_n_q, dp_n_d;

  logic                  slot_end, boundary, pwm_on, blank;
  logic [3:0]            cur_digit;
  logic [NDIGITS-1:0]    lz_mask;
  logic                  zero_above;

  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    logic [6:0] seg;
    unique case (h)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  assign slot_end = &div_cnt_q;
  assign boundary = slot_end && (idx_q == LastIdx);

  always_comb begin
    div_cnt_d   = div_cnt_q + 1'b1;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    if (slot_end) begin
      idx_d = boundary ? '0 : idx_q + 1'b1;
    end
    if (boundary) begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  // A write landing on the boundary cycle bypasses pend and commits directly.
  always_comb begin
    shadow_d   = shadow_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (boundary) begin
      if (wr_en) begin
        shadow_d = wr_data;
        pend_d   = wr_data;
      end else if (pend_vld_q) begin
        shadow_d = pend_q;
      end
      pend_vld_d = 1'b0;
    end else if (wr_en) begin
      pend_d     = wr_data;
      pend_vld_d = 1'b1;
    end
  end

  // lz_mask[i] is set when shadow digits i..NDIGITS-1 are all zero.
  always_comb begin
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int i = int'(NDIGITS) - 1; i >= 0; i--) begin
      zero_above = zero_above && (shadow_q[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_above;
    end
  end

  always_comb begin
    cur_digit = shadow_q[4*idx_q +: 4];
    pwm_on    = div_cnt_q[SCAN_BITS-1 -: 4] < bright;
    blank     = !dig_en[idx_q]
             || (blink_mask[idx_q] && blink_cnt_q[BLINK_LOG2])
             || (lz_en && (idx_q != '0) && lz_mask[idx_q]);
    an_d      = '1;
    a2g_d     = 7'h7F;
    dp_n_d    = 1'b1;
    if (pwm_on) begin
      an_d[idx_q] = 1'b0;
      if (!blank) begin
        a2g_d  = hex_decode(cur_digit);
        dp_n_d = ~dp_in[idx_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q   <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      shadow_q    <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      an_q        <= '1;
      a2g_q       <= 7'h7F;
      dp_n_q      <= 1'b1;
    end else begin
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      shadow_q    <= shadow_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      an_q        <= an_d;
      a2g_q       <= a2g_d;
      dp_n_q      <= dp_n_d;
    end
  end

  assign upd_pending = pend_vld_q;
  assign frame_tick  = boundary;
  assign an          = an_q;
  assign a2g         = a2g_q;
  assign dp_n        = dp_n_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 16-cycle slots, 8 digits (128-cycle frames)
// and a 2-frame blink half-period.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  dig_en, dp_in, blink_mask;
  logic        lz_en;
  logic [3:0]  bright;
  logic        upd_pending, frame_tick, dp_n;
  logic [6:0]  a2g;
  logic [7:0]  an;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  seg7_scan_ctrl #(
    .NDIGITS   (8),
    .SCAN_BITS (4),
    .BLINK_LOG2(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .dig_en     (dig_en),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .lz_en      (lz_en),
    .bright     (bright),
    .upd_pending(upd_pending),
    .frame_tick (frame_tick),
    .a2g        (a2g),
    .dp_n       (dp_n),
    .an         (an)
  );

  always #5 clk = ~clk;

  // Clock edges since reset released; outputs at negedge cyc reflect scan state cyc-1.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; wr_en = 1'b0; wr_data = '0;
    dig_en = 8'hFF; dp_in = 8'h00; blink_mask = 8'h00; lz_en = 1'b0; bright = 4'd15;
    repeat (3) @(negedge clk);
    total++; if (an !== 8'hFF) begin bad++; $display("FAIL rst_an got=%h want=ff", an); end
    total++; if (a2g !== 7'h7F) begin bad++; $display("FAIL rst_a2g got=%h want=7f", a2g); end
    total++; if (dp_n !== 1'b1) begin bad++; $display("FAIL rst_dp got=%b want=1", dp_n); end
    total++;
    if (upd_pending !== 1'b0) begin bad++; $display("FAIL rst_pend got=%b want=0", upd_pending); end
    total++;
    if (frame_tick !== 1'b0) begin bad++; $display("FAIL rst_tick got=%b want=0", frame_tick); end
  endtask

  task automatic test_commit_scan;
    logic [6:0] exp_seg [8];
    exp_seg = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    reset = 1'b0; wr_en = 1'b1; wr_data = 32'h1234_5678;
    @(negedge clk);
    wr_en = 1'b0;
    total++; if (upd_pending !== 1'b1) begin bad++; $display("FAIL t1_pend got=%b want=1", upd_pending); end
    total++; if (a2g !== 7'h40) begin bad++; $display("FAIL t1_old a2g got=%h want=40", a2g); end
    goto(127);
    total++; if (frame_tick !== 1'b1) begin bad++; $display("FAIL t1_tick got=%b want=1", frame_tick); end
    total++;
    if (upd_pending !== 1'b1) begin bad++; $display("FAIL t1_pend127 got=%b want=1", upd_pending); end
    goto(128);
    total++;
    if (upd_pending !== 1'b0) begin bad++; $display("FAIL t1_pend128 got=%b want=0", upd_pending); end
    for (int k = 0; k < 8; k++) begin
      goto(129 + 16*k);
      total++;
      if (an !== ~(8'h01 << k)) begin
        bad++; $display("FAIL t1_an slot%0d got=%h want=%h", k, an, ~(8'h01 << k));
      end
      total++;
      if (a2g !== exp_seg[k]) begin
        bad++; $display("FAIL t1_a2g slot%0d got=%h want=%h", k, a2g, exp_seg[k]);
      end
      goto(144 + 16*k);
      total++;
      if (an !== 8'hFF) begin bad++; $display("FAIL t1_pwm_off slot%0d got=%h want=ff", k, an); end
    end
  endtask

  task automatic test_latest_wins;
    goto(260); wr_en = 1'b1; wr_data = 32'h0000_0001;
    @(negedge clk); wr_en = 1'b0;
    goto(265); wr_en = 1'b1; wr_data = 32'h0000_0002;
    @(negedge clk); wr_en = 1'b0;
    goto(271);
    total++; if (a2g !== 7'h00) begin bad++; $display("FAIL t2_hold got=%h want=00", a2g); end
    goto(300);
    total++; if (upd_pending !== 1'b1) begin bad++; $display("FAIL t2_pend got=%b want=1", upd_pending); end
    goto(385);
    total++; if (an !== 8'hFE) begin bad++; $display("FAIL t2_an got=%h want=fe", an); end
    total++; if (a2g !== 7'h24) begin bad++; $display("FAIL t2_a2g got=%h want=24", a2g); end
  endtask

  task automatic test_boundary_write;
    goto(511);
    total++; if (frame_tick !== 1'b1) begin bad++; $display("FAIL t3_tick got=%b want=1", frame_tick); end
    wr_en = 1'b1; wr_data = 32'h0000_00A9;
    @(negedge clk);
    wr_en = 1'b0; dp_in = 8'h02; dig_en = 8'hFB;
    total++; if (upd_pending !== 1'b0) begin bad++; $display("FAIL t3_pend got=%b want=0", upd_pending); end
    goto(513);
    total++; if (a2g !== 7'h10) begin bad++; $display("FAIL t3_d0 got=%h want=10", a2g); end
    total++; if (dp_n !== 1'b1) begin bad++; $display("FAIL t3_dp0 got=%b want=1", dp_n); end
    goto(529);
    total++; if (a2g !== 7'h08) begin bad++; $display("FAIL t3_d1 got=%h want=08", a2g); end
    total++; if (dp_n !== 1'b0) begin bad++; $display("FAIL t3_dp1 got=%b want=0", dp_n); end
    goto(545);
    total++; if (an !== 8'hFB) begin bad++; $display("FAIL t3_dis_an got=%h want=fb", an); end
    total++; if (a2g !== 7'h7F) begin bad++; $display("FAIL t3_dis_a2g got=%h want=7f", a2g); end
  endtask

  task automatic test_lz_blank;
    goto(560); wr_en = 1'b1; wr_data = 32'h0000_0050; dig_en = 8'hFF; dp_in = 8'h00;
    @(negedge clk); wr_en = 1'b0;
    goto(639); lz_en = 1'b1; dp_in = 8'hFF;
    goto(641);
    total++; if (a2g !== 7'h40) begin bad++; $display("FAIL t4_d0 got=%h want=40", a2g); end
    total++; if (dp_n !== 1'b0) begin bad++; $display("FAIL t4_dp0 got=%b want=0", dp_n); end
    goto(650); wr_en = 1'b1; wr_data = 32'h0000_0000;
    @(negedge clk); wr_en = 1'b0;
    goto(657);
    total++; if (a2g !== 7'h12) begin bad++; $display("FAIL t4_d1 got=%h want=12", a2g); end
    goto(673);
    total++; if (an !== 8'hFB) begin bad++; $display("FAIL t4_d2_an got=%h want=fb", an); end
    total++; if (a2g !== 7'h7F) begin bad++; $display("FAIL t4_d2_a2g got=%h want=7f", a2g); end
    total++; if (dp_n !== 1'b1) begin bad++; $display("FAIL t4_d2_dp got=%b want=1", dp_n); end
    goto(753);
    total++; if (a2g !== 7'h7F) begin bad++; $display("FAIL t4_d7 got=%h want=7f", a2g); end
    goto(769);
    total++; if (a2g !== 7'h40) begin bad++; $display("FAIL t4_zero_d0 got=%h want=40", a2g); end
    goto(785);
    total++; if (a2g !== 7'h7F) begin bad++; $display("FAIL t4_zero_d1 got=%h want=7f", a2g); end
  endtask

  task automatic test_pwm;
    int on_cnt;
    goto(895); lz_en = 1'b0; dp_in = 8'h00; bright = 4'd4;
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an !== 8'hFF) on_cnt++;
    end
    total++; if (on_cnt != 4) begin bad++; $display("FAIL t5_duty4 got=%0d want=4", on_cnt); end
    bright = 4'd0;
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an !== 8'hFF) on_cnt++;
    end
    total++; if (on_cnt != 0) begin bad++; $display("FAIL t5_duty0 got=%0d want=0", on_cnt); end
    bright = 4'd15;
  endtask

  task automatic test_blink;
    goto(1023); blink_mask = 8'h01;
    goto(1025);
    total++; if (a2g !== 7'h40) begin bad++; $display("FAIL t6_f8 got=%h want=40", a2g); end
    goto(1153);
    total++; if (a2g !== 7'h40) begin bad++; $display("FAIL t6_f9 got=%h want=40", a2g); end
    goto(1281);
    total++; if (a2g !== 7'h7F) begin bad++; $display("FAIL t6_f10 got=%h want=7f", a2g); end
    total++; if (an !== 8'hFE) begin bad++; $display("FAIL t6_f10_an got=%h want=fe", an); end
    goto(1297);
    total++; if (a2g !== 7'h40) begin bad++; $display("FAIL t6_f10_d1 got=%h want=40", a2g); end
    goto(1409);
    total++; if (a2g !== 7'h7F) begin bad++; $display("FAIL t6_f11 got=%h want=7f", a2g); end
    goto(1537);
    total++; if (a2g !== 7'h40) begin bad++; $display("FAIL t6_f12 got=%h want=40", a2g); end
  endtask

  task automatic test_mid_reset;
    goto(1550); wr_en = 1'b1; wr_data = 32'h0000_0003;
    @(negedge clk); wr_en = 1'b0;
    goto(1560); reset = 1'b1;
    @(negedge clk);
    total++; if (an !== 8'hFF) begin bad++; $display("FAIL mr_an got=%h want=ff", an); end
    total++; if (a2g !== 7'h7F) begin bad++; $display("FAIL mr_a2g got=%h want=7f", a2g); end
    total++;
    if (upd_pending !== 1'b0) begin bad++; $display("FAIL mr_pend got=%b want=0", upd_pending); end
    @(negedge clk); reset = 1'b0;
    goto(1);
    total++; if (an !== 8'hFE) begin bad++; $display("FAIL mr_idx0 got=%h want=fe", an); end
    total++; if (a2g !== 7'h40) begin bad++; $display("FAIL mr_seg0 got=%h want=40", a2g); end
    goto(17);
    total++; if (an !== 8'hFD) begin bad++; $display("FAIL mr_idx1 got=%h want=fd", an); end
    goto(129);
    total++; if (a2g !== 7'h40) begin bad++; $display("FAIL mr_discard got=%h want=40", a2g); end
  endtask

  initial begin
    test_reset();
    test_commit_scan();
    test_latest_wins();
    test_boundary_write();
    test_lz_blank();
    test_pwm();
    test_blink();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
